ttl_74191_sync: RTL



---
 rtl/ttl_74191_tc.sv | 13 +
 rtl/ttl_74191_sync.sv | 68 ++++++
 2 files changed

// File: rtl/ttl_74191_tc.sv
// rtl/ttl_74191_tc.sv - terminal-count detect for the 74191-style up/down counter
module ttl_74191_tc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             down_up_i,
    output logic             max_min_o
);

    // Terminal value is zero when counting down, all-ones when counting up.
    assign max_min_o = down_up_i ? (q_i == '0) : (q_i == '1);

endmodule

// File: rtl/ttl_74191_sync.sv
// rtl/ttl_74191_sync.sv - synchronous presettable cascadable up/down counter
module ttl_74191_sync #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0,
    parameter int DELAY_RISE  = 0,
    parameter int DELAY_FALL  = 0
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Load_bar,
    input  logic             Enable_bar,
    input  logic             Down_Up,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Max_Min,
    output logic             RCO_bar
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc;

    ttl_74191_tc #(
        .WIDTH(WIDTH)
    ) u_tc (
        .q_i      (q_q),
        .down_up_i(Down_Up),
        .max_min_o(tc)
    );

    always_comb begin
        q_d = q_q;
        if (!Load_bar) begin
            q_d = D;
        end else if (!Enable_bar) begin
            // In reload mode the terminal count reloads D instead of wrapping.
            if (AUTO_RELOAD && tc) begin
                q_d = D;
            end else if (Down_Up) begin
                q_d = q_q - ONE;
            end else begin
                q_d = q_q + ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Output delays only shape the behavioural model; hardware is direct wiring either way.
    if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_out_nodelay
        assign Q       = q_q;
        assign Max_Min = tc;
        assign RCO_bar = ~(~Enable_bar & tc);
    end else begin : g_out_delay_ignored
        assign Q       = q_q;
        assign Max_Min = tc;
        assign RCO_bar = ~(~Enable_bar & tc);
    end

endmodule
